mem_access_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one N-word register-file memory between NUM_REQ requesters. It accepts one read or write request at a time and latches its address and data. It drives the memory's one-hot word-select lines and read/write strobes through a fixed 4-state sequence. It returns an ack pulse, plus read data for reads, to the granted requester. It sits between requester ports and the word-select decode/storage array.

---
 rtl/mem_access_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_arbiter: round-robin arbiter/sequencer sharing one register-  |
// | file memory between NUM_REQ requesters. Optional macro MEM_ACC_ADDR_ERR_EN|
// | adds the addr_err output. Revision: 1.0                                  |
// +--------------------------------------------------------------------------+
module mem_access_arbiter #(
  parameter int N             = 16,
  parameter int no_addr_lines = 4,
  parameter int WIDTH         = 8,
  parameter int NUM_REQ       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               we,
  input  logic [NUM_REQ*no_addr_lines-1:0] addr,
  input  logic [NUM_REQ*WIDTH-1:0]         wdata,
  input  logic [WIDTH-1:0]                 mem_rdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               ack,
  output logic [WIDTH-1:0]                 rdata,
  output logic [N-1:0]                     word_select_lines,
  output logic                             mem_we,
  output logic                             mem_re,
  output logic [WIDTH-1:0]                 mem_wdata,
  output logic                             busy
`ifdef MEM_ACC_ADDR_ERR_EN
  ,
  output logic                             addr_err
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         win_q, win_d;
  logic                     op_we_q, op_we_d;
  logic [no_addr_lines-1:0] op_addr_q, op_addr_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic [WIDTH-1:0]         rdata_q, rdata_d;
  logic [N-1:0]             wsl_q, wsl_d;
  logic                     mem_we_q, mem_we_d;
  logic                     mem_re_q, mem_re_d;
  logic [WIDTH-1:0]         mem_wdata_q, mem_wdata_d;
  logic                     busy_q, busy_d;
`ifdef MEM_ACC_ADDR_ERR_EN
  logic                     addr_err_q, addr_err_d;
`endif

  logic                     arb_found;
  logic [IDX_W-1:0]         arb_idx;
  logic [IDX_W-1:0]         arb_cand;
  logic [no_addr_lines-1:0] arb_addr;
  logic [WIDTH-1:0]         arb_wdata;
  logic [N-1:0]             arb_sel;
  logic                     addr_ok;

  // First asserted request at or above the pointer, wrapping to 0.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!arb_found && req[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  assign arb_addr  = addr[arb_idx*no_addr_lines +: no_addr_lines];
  assign arb_wdata = wdata[arb_idx*WIDTH +: WIDTH];
  assign addr_ok   = (int'(op_addr_q) < N);

  // Out-of-range addresses decode to an all-zero select.
  always_comb begin
    arb_sel = '0;
    for (int i = 0; i < N; i++) begin
      arb_sel[i] = (int'(arb_addr) == i);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    op_we_d     = op_we_q;
    op_addr_d   = op_addr_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    wsl_d       = wsl_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
`ifdef MEM_ACC_ADDR_ERR_EN
    addr_err_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d     = S_GRANT;
          win_d       = arb_idx;
          op_we_d     = we[arb_idx];
          op_addr_d   = arb_addr;
          gnt_d       = NUM_REQ'(1) << arb_idx;
          wsl_d       = arb_sel;
          mem_wdata_d = arb_wdata;
          busy_d      = 1'b1;
        end
      end
      S_GRANT: begin
        state_d  = S_ACCESS;
        mem_we_d = op_we_q & addr_ok;
        mem_re_d = ~op_we_q & addr_ok;
      end
      S_ACCESS: begin
        state_d = S_ACK;
        ack_d   = gnt_q;
        if (!op_we_q) begin
          rdata_d = addr_ok ? mem_rdata : '0;
        end
`ifdef MEM_ACC_ADDR_ERR_EN
        addr_err_d = ~addr_ok;
`endif
      end
      S_ACK: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        wsl_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + IDX_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      op_we_q     <= 1'b0;
      op_addr_q   <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      wsl_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_ACC_ADDR_ERR_EN
      addr_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      op_we_q     <= op_we_d;
      op_addr_q   <= op_addr_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      wsl_q       <= wsl_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
`ifdef MEM_ACC_ADDR_ERR_EN
      addr_err_q  <= addr_err_d;
`endif
    end
  end

  assign gnt               = gnt_q;
  assign ack               = ack_q;
  assign rdata             = rdata_q;
  assign word_select_lines = wsl_q;
  assign mem_we            = mem_we_q;
  assign mem_re            = mem_re_q;
  assign mem_wdata         = mem_wdata_q;
  assign busy              = busy_q;
`ifdef MEM_ACC_ADDR_ERR_EN
  assign addr_err          = addr_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_arbiter: randomized bench for mem_access_arbiter against a |
// | transaction-timeline reference model. Revision: 1.0                      |
// +--------------------------------------------------------------------------+
module tb_mem_access_arbiter;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int W  = 8;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req, we;
  logic [NR*AW-1:0] addr;
  logic [NR*W-1:0] wdata;
  logic [W-1:0]    mem_rdata;
  logic [NR-1:0]   gnt, ack;
  logic [W-1:0]    rdata, mem_wdata;
  logic [N-1:0]    word_select_lines;
  logic            mem_we, mem_re, busy;
`ifdef MEM_ACC_ADDR_ERR_EN
  logic            addr_err;
`endif

  always #5 clk = ~clk;

  mem_access_arbiter #(.N(N), .no_addr_lines(AW), .WIDTH(W), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .mem_rdata(mem_rdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .word_select_lines(word_select_lines), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .busy(busy)
`ifdef MEM_ACC_ADDR_ERR_EN
    , .addr_err(addr_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] tb_mem [N];
  logic [W-1:0] ref_mem [N];
  bit           wr_pend;
  int           wr_idx;
  logic [W-1:0] wr_dat;

  // Reference timeline: phase 0 = no transaction, 1..3 = cycles since grant.
  int           m_phase, m_ptr, m_win, m_addr;
  logic         m_we;
  logic [W-1:0] m_wd, m_mwd, m_rdata;

  bit hold_all, rand_mode;
  bit pending [NR];

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < N; i++) if (word_select_lines[i]) mem_rdata = tb_mem[i];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_win = 0; m_addr = 0; m_we = 1'b0;
    m_wd = '0; m_mwd = '0; m_rdata = '0;
  endtask

  task automatic model_edge();
    bit found;
    int c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (req != '0) begin
        found = 0;
        for (int k = 0; k < NR; k++) begin
          c = (m_ptr + k) % NR;
          if (!found && ((req >> c) & 1) != 0) begin found = 1; m_win = c; end
        end
        m_we    = we[m_win];
        m_addr  = int'(addr[m_win*AW +: AW]);
        m_wd    = wdata[m_win*W +: W];
        m_mwd   = m_wd;
        m_phase = 1;
      end
      1: m_phase = 2;
      2: begin
        if (m_addr < N) begin
          if (m_we) ref_mem[m_addr] = m_wd;
          else      m_rdata = ref_mem[m_addr];
        end else if (!m_we) m_rdata = '0;
        m_phase = 3;
      end
      default: begin
        m_ptr   = (m_win + 1) % NR;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [NR-1:0] eg, ea;
    logic [N-1:0]  ew;
    bit            inr;
    inr = (m_addr < N);
    eg = '0; ea = '0; ew = '0;
    if (m_phase != 0) begin
      eg = NR'(1) << m_win;
      if (inr) ew = N'(1) << m_addr;
    end
    if (m_phase == 3) ea = NR'(1) << m_win;
    check("gnt", 64'(gnt), 64'(eg));
    check("ack", 64'(ack), 64'(ea));
    check("wsl", 64'(word_select_lines), 64'(ew));
    check("mem_we", 64'(mem_we), 64'(m_phase == 2 && m_we && inr));
    check("mem_re", 64'(mem_re), 64'(m_phase == 2 && !m_we && inr));
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("rdata", 64'(rdata), 64'(m_rdata));
    check("mem_wdata", 64'(mem_wdata), 64'(m_mwd));
`ifdef MEM_ACC_ADDR_ERR_EN
    check("addr_err", 64'(addr_err), 64'(m_phase == 3 && !inr));
`endif
  endtask

  task automatic drive_agents();
    if (m_phase == 3) begin
      req[m_win]     = hold_all;
      pending[m_win] = 0;
    end
    if (rand_mode) begin
      for (int i = 0; i < NR; i++) begin
        if (!pending[i] && $urandom_range(0, 3) == 0) begin
          pending[i]         = 1;
          req[i]             = 1'b1;
          we[i]              = 1'($urandom_range(0, 1));
          addr[i*AW +: AW]   = AW'($urandom);
          wdata[i*W +: W]    = W'($urandom);
        end else if (pending[i] && (m_phase == 1 || m_phase == 2) && m_win == i) begin
          addr[i*AW +: AW] = AW'($urandom);
          wdata[i*W +: W]  = W'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
        end
      end
    end
  endtask

  // The memory commits a write at the edge that ends the strobe cycle.
  task automatic step();
    @(posedge clk);
    if (wr_pend) tb_mem[wr_idx] = wr_dat;
    wr_pend = 0;
    model_edge();
    @(negedge clk);
    check_outputs();
    if (mem_we && word_select_lines != '0) begin
      wr_pend = 1;
      wr_dat  = mem_wdata;
      for (int i = 0; i < N; i++) if (word_select_lines[i]) wr_idx = i;
    end
    drive_agents();
  endtask

  task automatic raise(input int i, input logic w, input int a, input logic [W-1:0] d);
    req[i] = 1'b1; we[i] = w; addr[i*AW +: AW] = AW'(a); wdata[i*W +: W] = d; pending[i] = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ack_seen, exp_idx;
    bit any_pending;
    req = '0; we = '0; addr = '0; wdata = '0;
    hold_all = 0; rand_mode = 0; wr_pend = 0; wr_idx = 0; wr_dat = '0;
    for (int i = 0; i < NR; i++) pending[i] = 0;
    for (int i = 0; i < N; i++) begin tb_mem[i] = W'($urandom); ref_mem[i] = tb_mem[i]; end
    model_reset();

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();

    // Single write: requester 2, addr 5.
    raise(2, 1'b1, 5, 8'hA5);
    step();
    check("wr_gnt", 64'(gnt), 64'h4);
    step();
    check("wr_wsl", 64'(word_select_lines), 64'h0020);
    check("wr_strobe", 64'(mem_we), 64'h1);
    step();
    check("wr_ack", 64'(ack), 64'h4);
    step();
    check("wr_mem5", 64'(tb_mem[5]), 64'hA5);
    step();

    // Single read: requester 0, addr 15.
    tb_mem[15] = 8'h3C; ref_mem[15] = 8'h3C;
    raise(0, 1'b0, 15, 8'h00);
    repeat (2) step();
    check("rd_strobe", 64'({mem_re, word_select_lines}), 64'h1_8000);
    step();
    check("rd_ack", 64'(ack), 64'h1);
    check("rd_data", 64'(rdata), 64'h3C);
    repeat (2) step();

    // Requester 1 alone moves the pointer to 2; then 0 and 1 contend.
    raise(1, 1'b0, 3, 8'h00);
    repeat (4) step();
    raise(0, 1'b0, 7, 8'h00);
    raise(1, 1'b1, 9, 8'h77);
    repeat (3) step();
    check("cont_first", 64'(ack), 64'h1);
    repeat (4) step();
    check("cont_second", 64'(ack), 64'h2);
    repeat (2) step();

    // All requesters held high: acks rotate from the pointer (now 2).
    hold_all = 1;
    we = '0;
    for (int i = 0; i < NR; i++) addr[i*AW +: AW] = AW'($urandom);
    req = '1;
    ack_seen = 0; exp_idx = 2;
    for (int t = 0; t < 64; t++) begin
      step();
      if (ack != '0) begin
        check("rr_order", 64'(ack), 64'(NR'(1) << exp_idx));
        exp_idx = (exp_idx + 1) % NR;
        ack_seen++;
      end
    end
    check("rr_count", 64'(ack_seen), 64'd16);
    hold_all = 0;
    req = '0;
    for (int i = 0; i < NR; i++) pending[i] = 0;
    step();

    // Reset during the strobe cycle of a write aborts it.
    raise(3, 1'b1, 7, 8'h5A);
    repeat (2) step();
    #1 rst_n = 1'b0;
    model_reset();
    wr_pend = 0;
    req = '0;
    for (int i = 0; i < NR; i++) pending[i] = 0;
    #1 check_outputs();
    repeat (2) step();
    rst_n = 1'b1;
    check("abort_mem7", 64'(tb_mem[7]), 64'(ref_mem[7]));
    raise(1, 1'b0, 2, 8'h00);
    raise(3, 1'b0, 4, 8'h00);
    repeat (3) step();
    check("ptr_after_rst", 64'(ack), 64'h2);

    rand_mode = 1;
    repeat (400) step();
    rand_mode = 0;
    for (int t = 0; t < 40; t++) begin
      any_pending = 0;
      for (int i = 0; i < NR; i++) if (pending[i]) any_pending = 1;
      if (!any_pending && m_phase == 0) break;
      step();
    end
    req = '0;
    repeat (2) step();
    check("drain_busy", 64'(busy), 64'h0);
    for (int i = 0; i < N; i++) check("mem_final", 64'(tb_mem[i]), 64'(ref_mem[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
